// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one 256-bit cache-line fill or writeback into a
// burst of 64-bit beats on the physical-memory port. Only one line
// transaction is in flight at a time.
//
// Optional build macro: CACHELINE_ADAPTOR_TIMEOUT_EN
//   defined   -> a per-beat idle watchdog sets a sticky timeout_err after
//                TIMEOUT cycles without pmem_resp while a burst is active.
//   undefined -> no watchdog logic; timeout_err is tied low.

module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [31:0]        line_addr,
    input  logic [LINE_W-1:0]  line_wdata,
    output logic [LINE_W-1:0]  line_rdata,
    output logic               line_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    output logic [BURST_W-1:0] pmem_wdata,
    input  logic [BURST_W-1:0] pmem_rdata,
    input  logic               pmem_resp,
    output logic               timeout_err
);

    localparam int unsigned BEATS  = LINE_W / BURST_W;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                last_beat;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [LINE_W-1:0]   rbuf_q, rbuf_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [BURST_W-1:0]  wdata_q, wdata_d;
    logic                resp_q, resp_d;

    // Byte offset within the line is never used; the burst is line-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^line_addr[OFF_W-1:0];

    assign cnt_nxt   = cnt_q + CNT_W'(1);
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        resp_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Read has priority when both requests are raised together.
                if (line_read) begin
                    addr_d  = {line_addr[31:OFF_W], OFF_W'(0)};
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    state_d = READ;
                end else if (line_write) begin
                    addr_d  = {line_addr[31:OFF_W], OFF_W'(0)};
                    wbuf_d  = line_wdata;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    wdata_d = line_wdata[BURST_W-1:0];
                    state_d = WRITE;
                end
            end

            READ: begin
                rd_d = 1'b1;
                if (pmem_resp) begin
                    rbuf_d[int'(cnt_q)*BURST_W +: BURST_W] = pmem_rdata;
                    if (last_beat) begin
                        rd_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end

            WRITE: begin
                wr_d = 1'b1;
                if (pmem_resp) begin
                    if (last_beat) begin
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_nxt;
                        wdata_d = wbuf_q[int'(cnt_nxt)*BURST_W +: BURST_W];
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, buffers and registered outputs; reset drops every output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
        end
    end

    assign line_rdata   = rbuf_q;
    assign line_resp    = resp_q;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q;
    logic              err_q;
    logic              busy;

    assign busy = (state_q == READ) || (state_q == WRITE);

    // Per-beat idle watchdog; saturates at TIMEOUT, error is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else if (busy && !pmem_resp) begin
            if (idle_q != IDLE_W'(TIMEOUT)) begin
                idle_q <= idle_q + IDLE_W'(1);
            end
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                err_q <= 1'b1;
            end
        end else begin
            idle_q <= '0;
        end
    end

    assign timeout_err = err_q;
`else
    // No watchdog in this build; the limit only matters when it is enabled.
    assign timeout_err = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a table of line transactions driven
// through a simple memory responder, plus hand sequences for reset and the
// watchdog.

module tb_cacheline_adaptor;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;

    logic               clk;
    logic               rst;
    logic               line_read;
    logic               line_write;
    logic [31:0]        line_addr;
    logic [LINE_W-1:0]  line_wdata;
    logic [LINE_W-1:0]  line_rdata;
    logic               line_resp;
    logic               pmem_read;
    logic               pmem_write;
    logic [31:0]        pmem_address;
    logic [BURST_W-1:0] pmem_wdata;
    logic [BURST_W-1:0] pmem_rdata;
    logic               pmem_resp;
    logic               timeout_err;

    int n_cmp;
    int n_bad;

    cacheline_adaptor #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_addr    (line_addr),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] wdata;
        logic [255:0] mem_line;
        int          gap;
        logic [31:0] exp_addr;
        logic [255:0] exp_rdata;
        int          exp_resp_cyc;
    } vec_t;

    task automatic chk(input int id, input string name,
                       input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%0d] %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // Issue one line request, answer it from v.mem_line with v.gap idle
    // cycles between beats, and check the handshake cycle by cycle.
    task automatic run_txn(input int id, input vec_t v);
        int cyc;
        int beat;
        int idle;
        int resp_cyc;
        bit done;
        @(negedge clk);
        line_read  = v.rd;
        line_write = v.wr;
        line_addr  = v.addr;
        line_wdata = v.wdata;
        pmem_resp  = 1'b0;
        cyc = 0; beat = 0; idle = 0; resp_cyc = -1; done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            pmem_resp = 1'b0;
            if (line_resp) begin
                resp_cyc   = cyc;
                done       = 1'b1;
                line_read  = 1'b0;
                line_write = 1'b0;
            end else begin
                chk(id, "pmem_read",    256'(pmem_read),    256'(v.rd));
                chk(id, "pmem_write",   256'(pmem_write),   256'(v.wr & ~v.rd));
                chk(id, "pmem_address", 256'(pmem_address), 256'(v.exp_addr));
                if (beat < 4 && (beat == 0 || idle == v.gap)) begin
                    pmem_resp = 1'b1;
                    idle      = 0;
                    if (v.rd) begin
                        pmem_rdata = v.mem_line[beat*64 +: 64];
                    end else begin
                        chk(id, "pmem_wdata", 256'(pmem_wdata),
                            256'(v.wdata[beat*64 +: 64]));
                    end
                    beat++;
                end else begin
                    idle++;
                end
            end
        end
        chk(id, "resp_cycle", 256'(resp_cyc), 256'(v.exp_resp_cyc));
        chk(id, "line_rdata", line_rdata, v.exp_rdata);
        @(negedge clk);
        chk(id, "resp_pulse", 256'(line_resp), 256'(0));
        chk(id, "read_drop",  256'(pmem_read), 256'(0));
        chk(id, "write_drop", 256'(pmem_write), 256'(0));
        chk(id, "rdata_hold", line_rdata, v.exp_rdata);
        @(negedge clk);
        chk(id, "no_2nd_resp", 256'(line_resp), 256'(0));
        chk(id, "idle_write",  256'(pmem_write), 256'(0));
    endtask

    localparam logic [255:0] L_A = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] L_W = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                    64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    localparam logic [255:0] L_B = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                    64'hDEADBEEFCAFEF00D, 64'h0F0F0F0FF0F0F0F0};
    localparam logic [255:0] L_C = {64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE,
                                    64'h5555555555555555, 64'hAAAAAAAA00000000};
    localparam logic [255:0] L_D = {64'h1000000000000004, 64'h1000000000000003,
                                    64'h1000000000000002, 64'h1000000000000001};
    localparam logic [255:0] L_E = {64'h9999999999999999, 64'h8888888888888888,
                                    64'h7777777777777777, 64'h6666666666666666};

    vec_t vecs[6];
    vec_t v_fresh;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        line_read  = 1'b0;
        line_write = 1'b0;
        line_addr  = '0;
        line_wdata = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        //            rd    wr    addr           wdata  mem   gap exp_addr       exp_rdata resp
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, '0,    L_A,  0,  32'h0000_1220, L_A,  5};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_1234, '0,    L_A,  3,  32'h0000_1220, L_A,  14};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_8000, L_W,   '0,   0,  32'h0000_8000, L_A,  5};
        vecs[3] = '{1'b1, 1'b1, 32'hABCD_EF1F, L_C,   L_B,  0,  32'hABCD_EF00, L_B,  5};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, L_C,   '0,   1,  32'hFFFF_FFE0, L_B,  8};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, '0,    L_D,  2,  32'h0000_0000, L_D,  11};
        v_fresh = '{1'b1, 1'b0, 32'h4000_005C, '0,    L_E,  0,  32'h4000_0040, L_E,  5};

        // Reset values while reset is held.
        #12;
        chk(0, "rst_pmem_read",  256'(pmem_read),    256'(0));
        chk(0, "rst_pmem_write", 256'(pmem_write),   256'(0));
        chk(0, "rst_line_resp",  256'(line_resp),    256'(0));
        chk(0, "rst_address",    256'(pmem_address), 256'(0));
        chk(0, "rst_wdata",      256'(pmem_wdata),   256'(0));
        chk(0, "rst_rdata",      line_rdata,         256'(0));
        chk(0, "rst_timeout",    256'(timeout_err),  256'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(i + 1, vecs[i]);
        end

        // Reset after two beats of a read: outputs drop at once, line discarded.
        @(negedge clk);
        line_read = 1'b1;
        line_addr = 32'h4000_0040;
        @(negedge clk);
        chk(20, "mid_pmem_read", 256'(pmem_read), 256'(1));
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hBAD0BAD0BAD0BAD0;
        @(negedge clk);
        pmem_rdata = 64'hBAD1BAD1BAD1BAD1;
        @(negedge clk);
        pmem_resp = 1'b0;
        line_read = 1'b0;
        rst       = 1'b1;
        #1;
        chk(20, "mid_rst_pmem_read", 256'(pmem_read),    256'(0));
        chk(20, "mid_rst_line_resp", 256'(line_resp),    256'(0));
        chk(20, "mid_rst_rdata",     line_rdata,         256'(0));
        chk(20, "mid_rst_address",   256'(pmem_address), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        run_txn(21, v_fresh);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        // Withhold pmem_resp for 16 cycles, then finish the read normally.
        @(negedge clk);
        line_read = 1'b1;
        line_addr = 32'h0000_0100;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 16) begin
                chk(30, "to_before", 256'(timeout_err), 256'(0));
            end
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin
                chk(30, "to_set", 256'(timeout_err), 256'(1));
            end
            pmem_resp  = 1'b1;
            pmem_rdata = L_D[b*64 +: 64];
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        chk(30, "to_resp",  256'(line_resp), 256'(1));
        chk(30, "to_rdata", line_rdata,      L_D);
        line_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(30, "to_sticky", 256'(timeout_err), 256'(1));
`else
        chk(30, "to_tied_low", 256'(timeout_err), 256'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
